pot_scan: RTL and testbench

POT_SCAN -- requirements
Module: pot_scan

---
 rtl/pot_scan_pkg.sv | 15 +
 rtl/pot_hyst_cmp.sv | 25 ++
 rtl/pot_scan.sv | 99 +++++++++
 tb/tb_pot_scan.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pot_scan_pkg.sv
// Shared types and defaults for the potentiometer scanner.
// No logic; FSM state encoding and default parameter values only.
package pot_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STRT = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [17:0] DEF_CH_MAP  = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
   localparam int          DEF_TMO_CYC = 1024;
   localparam int          DEF_HYST    = 4;

endpackage

// File: rtl/pot_hyst_cmp.sv
// Deadband compare: write enable when the slot is empty or |res - stored| > HYST.
// Purely combinational, zero latency; no handshake.
module pot_hyst_cmp
   import pot_scan_pkg::*;
#(
   parameter int RES_W = 12,
   parameter int HYST  = DEF_HYST
) (
   input  logic [RES_W-1:0] res,
   input  logic [RES_W-1:0] stored,
   input  logic             vld,
   output logic             wr_en
);

   localparam logic [RES_W:0] HYST_L = (RES_W+1)'(HYST);

   logic [RES_W:0] diff;

   always_comb begin
      if (res >= stored) diff = {1'b0, res} - {1'b0, stored};
      else               diff = {1'b0, stored} - {1'b0, res};
      wr_en = !vld || (diff > HYST_L);
   end

endmodule

// File: rtl/pot_scan.sv
// Round-robin ADC scanner storing one filtered value per potentiometer slot.
// Results land one cycle after cnv_cmplt; a silent ADC is abandoned after TMO_CYC WAIT cycles.
module pot_scan
   import pot_scan_pkg::*;
#(
   parameter int                      NUM_CH  = 6,
   parameter int                      RES_W   = 12,
   parameter int                      CH_W    = 3,
   parameter logic [NUM_CH*CH_W-1:0]  CH_MAP  = DEF_CH_MAP,
   parameter int                      HYST    = DEF_HYST,
   parameter int                      TMO_CYC = DEF_TMO_CYC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    cnv_cmplt,
   input  logic [RES_W-1:0]        res,
   output logic                    strt_cnv,
   output logic [CH_W-1:0]         chnnl,
   output logic [NUM_CH*RES_W-1:0] pot,
   output logic [NUM_CH-1:0]       pot_vld,
   output logic [NUM_CH-1:0]       upd,
   output logic                    timeout_err
);

   localparam int IDX_W = $clog2(NUM_CH);
   localparam int TMO_W = $clog2(TMO_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [TMO_W-1:0] tmo_cnt_q;
   logic [RES_W-1:0] pot_q  [NUM_CH];
   logic [CH_W-1:0]  ch_map [NUM_CH];
   logic             wr_en, tmo_hit, in_wait, conv_done, conv_tmo;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign ch_map[i]               = CH_MAP[i*CH_W +: CH_W];
      assign pot[i*RES_W +: RES_W]   = pot_q[i];
   end

   assign tmo_hit = (tmo_cnt_q == TMO_LAST);
   // Force slot 0's channel while reset is held so the mux never shows a stale select.
   assign chnnl   = rst ? ch_map[0] : ch_map[idx_q];

   pot_hyst_cmp #(.RES_W(RES_W), .HYST(HYST)) u_hyst (
      .res    (res),
      .stored (pot_q[idx_q]),
      .vld    (pot_vld[idx_q]),
      .wr_en  (wr_en)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = STRT;
         STRT:    state_d = WAIT;
         WAIT:    if (conv_done || conv_tmo) state_d = en ? STRT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      strt_cnv  = (state_q == STRT);
      in_wait   = (state_q == WAIT);
      conv_done = in_wait && cnv_cmplt;
      // A completion in the final WAIT cycle takes priority over the timeout.
      conv_tmo  = in_wait && !cnv_cmplt && tmo_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         tmo_cnt_q   <= '0;
         pot_vld     <= '0;
         upd         <= '0;
         timeout_err <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) pot_q[i] <= '0;
      end else begin
         upd <= '0;
         if (strt_cnv)     tmo_cnt_q <= '0;
         else if (in_wait) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         if (conv_done && wr_en) begin
            pot_q[idx_q]   <= res;
            pot_vld[idx_q] <= 1'b1;
            upd[idx_q]     <= 1'b1;
         end
         if (conv_tmo) timeout_err <= 1'b1;
         if (conv_done || conv_tmo) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

endmodule

// File: tb/tb_pot_scan.sv
// Bench for pot_scan: hand table, corner sequences and randomized scans against a slot-level model.
module tb_pot_scan;

   localparam int NUM_CH  = 6;
   localparam int RES_W   = 12;
   localparam int CH_W    = 3;
   localparam int HYST    = 4;
   localparam int TMO_CYC = 1024;
   localparam logic [NUM_CH*CH_W-1:0] MAP = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

   logic                    clk = 1'b0;
   logic                    rst, en, cnv_cmplt;
   logic [RES_W-1:0]        res;
   logic                    strt_cnv;
   logic [CH_W-1:0]         chnnl;
   logic [NUM_CH*RES_W-1:0] pot;
   logic [NUM_CH-1:0]       pot_vld, upd;
   logic                    timeout_err;

   pot_scan #(
      .NUM_CH(NUM_CH), .RES_W(RES_W), .CH_W(CH_W), .CH_MAP(MAP), .HYST(HYST), .TMO_CYC(TMO_CYC)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cnv_cmplt(cnv_cmplt), .res(res),
      .strt_cnv(strt_cnv), .chnnl(chnnl), .pot(pot), .pot_vld(pot_vld),
      .upd(upd), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int               ch_tbl [NUM_CH] = '{0, 1, 2, 3, 4, 7};
   logic [RES_W-1:0] mdl_pot [NUM_CH];
   bit               mdl_vld [NUM_CH];
   int               mdl_idx;
   bit               mdl_err;

   typedef struct {
      int               d;
      logic [RES_W-1:0] r;
      bit               wr;
      logic [RES_W-1:0] val;
      int               ch;
   } vec_t;
   vec_t tbl [$];

   task automatic add(input int d, input logic [RES_W-1:0] r, input bit wr,
                      input logic [RES_W-1:0] val, input int ch);
      vec_t v;
      v.d = d; v.r = r; v.wr = wr; v.val = val; v.ch = ch;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         mdl_pot[i] = '0;
         mdl_vld[i] = 1'b0;
      end
      mdl_idx = 0;
      mdl_err = 1'b0;
   endtask

   function automatic logic [NUM_CH*RES_W-1:0] exp_pot();
      logic [NUM_CH*RES_W-1:0] p;
      for (int i = 0; i < NUM_CH; i++) p[i*RES_W +: RES_W] = mdl_pot[i];
      return p;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_vld();
      logic [NUM_CH-1:0] v;
      for (int i = 0; i < NUM_CH; i++) v[i] = mdl_vld[i];
      return v;
   endfunction

   task automatic wait_strt(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (strt_cnv) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) check("strt_timeout", 0, 1);
   endtask

   // One conversion: d idle WAIT cycles then a result; d >= TMO_CYC means the ADC stays silent.
   task automatic convert(input int d, input logic [RES_W-1:0] r, input bit drop_en,
                          input bit glitch, output int ch_seen);
      bit ok;
      int slot, diff;
      bit wr;
      logic [NUM_CH-1:0] exp_upd;
      ch_seen = -1;
      wait_strt(ok);
      if (!ok) return;
      slot    = mdl_idx;
      ch_seen = int'(chnnl);
      check("strt_chnnl", chnnl, ch_tbl[slot]);
      cnv_cmplt = glitch;
      res       = RES_W'($urandom);
      step();
      cnv_cmplt = 1'b0;
      check("strt_one_cycle", strt_cnv, 0);
      check("wait_chnnl", chnnl, ch_tbl[slot]);
      if (drop_en) en = 1'b0;
      wr = 1'b0;
      if (d >= TMO_CYC) begin
         repeat (TMO_CYC) step();
         mdl_err = 1'b1;
      end else begin
         repeat (d) step();
         cnv_cmplt = 1'b1;
         res       = r;
         step();
         cnv_cmplt = 1'b0;
         diff = int'(r) - int'(mdl_pot[slot]);
         if (diff < 0) diff = -diff;
         if (!mdl_vld[slot] || diff > HYST) begin
            wr            = 1'b1;
            mdl_pot[slot] = r;
            mdl_vld[slot] = 1'b1;
         end
      end
      exp_upd = '0;
      if (wr) exp_upd[slot] = 1'b1;
      mdl_idx = (slot + 1) % NUM_CH;
      check("upd", upd, exp_upd);
      check("pot", pot, exp_pot());
      check("pot_vld", pot_vld, exp_vld());
      check("timeout_err", timeout_err, mdl_err);
      check("next_strt", strt_cnv, en);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cnv_cmplt = 1'($urandom);
         res       = RES_W'($urandom);
         step();
         check("idle_upd", upd, 0);
         check("idle_strt", strt_cnv, 0);
      end
      cnv_cmplt = 1'b0;
   endtask

   task automatic advance_to(input int target);
      int ch;
      for (int i = 0; i < NUM_CH && mdl_idx != target; i++)
         convert(3, RES_W'($urandom), 1'b0, 1'b0, ch);
   endtask

   initial begin
      int ch, slot, d, x;
      bit drop;
      logic [RES_W-1:0] r, keep;

      rst = 1'b1; en = 1'b0; cnv_cmplt = 1'b0; res = '0;
      step();
      step();
      check("rst_strt", strt_cnv, 0);
      check("rst_pot", pot, 0);
      check("rst_vld", pot_vld, 0);
      check("rst_upd", upd, 0);
      check("rst_err", timeout_err, 0);
      check("rst_chnnl", chnnl, 0);
      rst = 1'b0;
      step();
      check("post_rst_chnnl", chnnl, 0);
      check("idle_no_strt", strt_cnv, 0);
      mdl_reset();
      en = 1'b1;

      add(19, 12'h100, 1, 12'h100, 0); add(19, 12'h101, 1, 12'h101, 1);
      add(19, 12'h102, 1, 12'h102, 2); add(19, 12'h103, 1, 12'h103, 3);
      add(19, 12'h104, 1, 12'h104, 4); add(19, 12'h107, 1, 12'h107, 7);
      add(3, 12'h200, 1, 12'h200, 0);  add(3, 12'h101, 0, 12'h101, 1);
      add(3, 12'h106, 0, 12'h102, 2);  add(3, 12'h108, 1, 12'h108, 3);
      add(3, 12'h0FF, 1, 12'h0FF, 4);  add(3, 12'h103, 0, 12'h107, 7);
      add(0, 12'h204, 0, 12'h200, 0);  add(0, 12'h0FD, 0, 12'h101, 1);
      add(0, 12'h0FD, 1, 12'h0FD, 2);  add(0, 12'h108, 0, 12'h108, 3);
      add(0, 12'h0FB, 0, 12'h0FF, 4);  add(0, 12'h10C, 1, 12'h10C, 7);
      add(1, 12'h205, 1, 12'h205, 0);  add(1, 12'hFFF, 1, 12'hFFF, 1);
      add(1, 12'h000, 1, 12'h000, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         slot = i % NUM_CH;
         convert(tbl[i].d, tbl[i].r, 1'b0, 1'b0, ch);
         check("tbl_ch", ch, tbl[i].ch);
         check("tbl_upd", upd, tbl[i].wr ? (1 << slot) : 0);
         check("tbl_val", pot[slot*RES_W +: RES_W], tbl[i].val);
         if (i == 5) begin
            check("scan_slot5", pot[5*RES_W +: RES_W], 12'h107);
            check("scan_vld", pot_vld, 6'h3F);
         end
      end

      // Result arriving in the very cycle the timeout would fire.
      convert(TMO_CYC - 1, 12'hABC, 1'b0, 1'b0, ch);
      check("tie_err", timeout_err, 0);
      check("tie_val", pot[3*RES_W +: RES_W], 12'hABC);

      advance_to(2);
      keep = pot[2*RES_W +: RES_W];
      convert(TMO_CYC, 12'h000, 1'b0, 1'b0, ch);
      check("tmo_err", timeout_err, 1);
      check("tmo_slot2", pot[2*RES_W +: RES_W], keep);
      check("tmo_next_ch", chnnl, 3);

      advance_to(1);
      convert(5, 12'h3C3, 1'b1, 1'b0, ch);
      check("drop_slot1", pot[1*RES_W +: RES_W], 12'h3C3);
      idle(6);
      en = 1'b1;
      convert(2, 12'h777, 1'b0, 1'b0, ch);
      check("resume_ch", ch, 2);

      for (int n = 0; n < 40; n++) begin
         slot = mdl_idx;
         x    = $urandom_range(0, 19);
         if (x == 0)      d = TMO_CYC;
         else if (x == 1) d = TMO_CYC - 1;
         else             d = $urandom_range(0, 25);
         if ($urandom_range(0, 1) == 1)
            r = mdl_pot[slot] + RES_W'($urandom_range(0, 10)) - RES_W'(5);
         else
            r = RES_W'($urandom);
         drop = ($urandom_range(0, 5) == 0);
         convert(d, r, drop, 1'($urandom), ch);
         if (drop) begin
            idle($urandom_range(1, 5));
            en = 1'b1;
         end
      end

      advance_to(3);
      wait_strt(drop);
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      check("rst_mid_chnnl", chnnl, 0);
      step();
      check("rstw_strt", strt_cnv, 0);
      check("rstw_pot", pot, 0);
      check("rstw_vld", pot_vld, 0);
      check("rstw_upd", upd, 0);
      check("rstw_err", timeout_err, 0);
      check("rstw_chnnl", chnnl, 0);
      rst = 1'b0;
      en  = 1'b1;
      mdl_reset();
      convert(4, 12'h055, 1'b0, 1'b0, ch);
      check("post_rst_first_ch", ch, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
